// File: rtl/nivel_caixa_sensor_acq_if.sv
// Probe inputs and validated level outputs of the tank-level acquisition front end.
// The producer side drives the raw probes; the acquisition block drives the levels.
interface nivel_caixa_sensor_acq_if;
    logic       probeHigh;
    logic       probeMedium;
    logic       probeLow;
    logic       highLevel;
    logic       mediumLevel;
    logic       lowLevel;
    logic [1:0] levelCode;
    logic       levelChanged;
    logic       sensorFault;

    modport master (
        output probeHigh, probeMedium, probeLow,
        input  highLevel, mediumLevel, lowLevel, levelCode, levelChanged, sensorFault
    );

    modport slave (
        input  probeHigh, probeMedium, probeLow,
        output highLevel, mediumLevel, lowLevel, levelCode, levelChanged, sensorFault
    );
endinterface

// File: rtl/nivel_caixa_sensor_acq.sv
// Water-tank probe acquisition: synchronise and debounce three level probes, reject
// physically impossible combinations, and publish a registered level with change/fault flags.
module nivel_caixa_sensor_acq #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FAULT_CYCLES    = 64,
    parameter int unsigned CNT_W           = 8
) (
    input logic                     clock,
    input logic                     resetN,
    nivel_caixa_sensor_acq_if.slave bus
);
    localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FaultLast = CNT_W'(FAULT_CYCLES - 1);

    typedef enum logic [1:0] {StValid, StSuspect, StFault, StRecover} state_e;

    logic [2:0]       raw;
    logic [2:0]       meta_q, sync_q;
    logic [2:0]       stable_q, stable_d;
    logic [CNT_W-1:0] deb_cnt_q [3];
    logic [CNT_W-1:0] deb_cnt_d [3];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic             plausible;
    logic             load;
    logic             sensor_fault;

    logic [2:0]       level_q;
    logic [1:0]       code_q, code_d;
    logic             changed_q;

    // Bit order everywhere is {high, medium, low}.
    assign raw = {bus.probeHigh, bus.probeMedium, bus.probeLow};

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = '0;
            if (sync_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    stable_d[i] = sync_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            meta_q   <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            meta_q    <= raw;
            sync_q    <= meta_q;
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Water fills bottom-up, so a wet probe implies every probe below it is wet.
    assign plausible = (stable_q == 3'b000) || (stable_q == 3'b001) ||
                       (stable_q == 3'b011) || (stable_q == 3'b111);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StValid;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StValid:   if (!plausible) state_d = StSuspect;
            StSuspect: begin
                if (plausible) begin
                    state_d = StValid;
                end else if (fault_cnt_q == FaultLast) begin
                    state_d = StFault;
                end
            end
            StFault:   if (plausible) state_d = StRecover;
            StRecover: begin
                if (!plausible) begin
                    state_d = StFault;
                end else if (fault_cnt_q == FaultLast) begin
                    state_d = StValid;
                end
            end
            default:   state_d = StValid;
        endcase

        // Shared counter: restarts on every transition, only runs while dwelling.
        fault_cnt_d = '0;
        if (state_d == state_q && (state_q == StSuspect || state_q == StRecover)) begin
            fault_cnt_d = fault_cnt_q + 1'b1;
        end
    end

    always_comb begin
        sensor_fault = (state_q == StFault) || (state_q == StRecover);
        load         = (state_q == StValid && plausible) ||
                       (state_q == StRecover && state_d == StValid);
    end

    always_comb begin
        code_d = 2'd0;
        if (stable_q[2]) begin
            code_d = 2'd3;
        end else if (stable_q[1]) begin
            code_d = 2'd2;
        end else if (stable_q[0]) begin
            code_d = 2'd1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            level_q   <= '0;
            code_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            changed_q <= load && (stable_q != level_q);
            if (load) begin
                level_q <= stable_q;
                code_q  <= code_d;
            end
        end
    end

    assign bus.highLevel    = level_q[2];
    assign bus.mediumLevel  = level_q[1];
    assign bus.lowLevel     = level_q[0];
    assign bus.levelCode    = code_q;
    assign bus.levelChanged = changed_q;
    assign bus.sensorFault  = sensor_fault;
endmodule

// File: tb/tb_nivel_caixa_sensor_acq.sv
// Bench for the tank-level acquisition block: random and scripted probe activity compared
// every cycle against a history-based reference model of the probe rules.
module tb_nivel_caixa_sensor_acq;
    localparam int unsigned Deb   = 4;
    localparam int unsigned Fault = 8;

    logic clock  = 1'b0;
    logic resetN = 1'b0;

    nivel_caixa_sensor_acq_if bus ();

    nivel_caixa_sensor_acq #(
        .DEBOUNCE_CYCLES(Deb),
        .FAULT_CYCLES   (Fault),
        .CNT_W          (8)
    ) dut (
        .clock (clock),
        .resetN(resetN),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: probe values seen two edges late, a probe's stable value follows it
    // once the last Deb samples all disagree; fault entry/exit counted in whole cycles.
    bit [2:0] m_meta, m_sync, m_stable;
    bit [2:0] hist[$];
    int       m_run;
    bit       m_fault;
    bit [2:0] m_lvl;
    bit [1:0] m_code;
    bit       m_changed;

    always @(posedge clock or negedge resetN) begin
        bit [2:0] combo;
        bit       plaus;
        bit       load;
        bit       all_diff;
        if (!resetN) begin
            m_meta = '0; m_sync = '0; m_stable = '0;
            hist.delete();
            m_run = 0; m_fault = 1'b0;
            m_lvl = '0; m_code = '0; m_changed = 1'b0;
        end else begin
            combo = m_stable;
            plaus = (combo == 3'b000) || (combo == 3'b001) ||
                    (combo == 3'b011) || (combo == 3'b111);
            load  = 1'b0;
            if (!m_fault) begin
                // Outputs follow only when the previous cycle was also plausible.
                if (plaus) begin
                    load  = (m_run == 0);
                    m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == int'(Fault) + 1) begin
                        m_fault = 1'b1;
                        m_run   = 0;
                    end
                end
            end else begin
                if (plaus) begin
                    m_run++;
                    if (m_run == int'(Fault) + 1) begin
                        m_fault = 1'b0;
                        m_run   = 0;
                        load    = 1'b1;
                    end
                end else begin
                    m_run = 0;
                end
            end
            m_changed = load && (combo != m_lvl);
            if (load) begin
                m_lvl  = combo;
                m_code = 2'($countones(combo));
            end

            hist.push_back(m_sync);
            if (hist.size() > Deb) void'(hist.pop_front());
            for (int i = 0; i < 3; i++) begin
                all_diff = (hist.size() == Deb);
                for (int k = 0; k < hist.size(); k++) begin
                    if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
                end
                if (all_diff) m_stable[i] = ~m_stable[i];
            end
            m_sync = m_meta;
            m_meta = {bus.probeHigh, bus.probeMedium, bus.probeLow};
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check_eq("high",    bus.highLevel,    m_lvl[2]);
            check_eq("medium",  bus.mediumLevel,  m_lvl[1]);
            check_eq("low",     bus.lowLevel,     m_lvl[0]);
            check_eq("code",    bus.levelCode,    m_code);
            check_eq("changed", bus.levelChanged, m_changed);
            check_eq("fault",   bus.sensorFault,  m_fault);
        end
    end

    task automatic drive(input logic [2:0] combo, input int cycles, input int bounce);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            if (c < bounce) begin
                {bus.probeHigh, bus.probeMedium, bus.probeLow} = combo ^ 3'($urandom_range(0, 7));
            end else begin
                {bus.probeHigh, bus.probeMedium, bus.probeLow} = combo;
            end
        end
    endtask

    logic [2:0] legal [4];
    logic [2:0] pick;
    int         len;

    initial begin
        legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b011; legal[3] = 3'b111;
        {bus.probeHigh, bus.probeMedium, bus.probeLow} = 3'b000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        chk_en = 1'b1;
        drive(3'b000, 4, 0);

        // Clean low-level edge: outputs move on exactly the 7th edge, one-cycle pulse.
        @(negedge clock);
        {bus.probeHigh, bus.probeMedium, bus.probeLow} = 3'b001;
        repeat (6) @(posedge clock);
        #1 check_eq("lat_before", bus.levelCode, 2'd0);
        @(posedge clock);
        #1 check_eq("lat_code", bus.levelCode, 2'd1);
        check_eq("lat_pulse", bus.levelChanged, 1'b1);
        @(posedge clock);
        #1 check_eq("lat_pulse_end", bus.levelChanged, 1'b0);
        drive(3'b001, 10, 0);

        // Medium probe bouncing every two cycles, then settling high.
        drive(3'b011, 2, 0); drive(3'b001, 2, 0); drive(3'b011, 2, 0); drive(3'b001, 2, 0);
        drive(3'b011, 20, 0);

        // Filling from empty with the medium probe lagging the low probe.
        drive(3'b000, 20, 0);
        drive(3'b001, 3, 0);
        drive(3'b011, 20, 0);
        drive(3'b111, 20, 0);

        // Stuck high probe, recovery, and a relapse part way through recovery.
        drive(3'b001, 15, 0);
        drive(3'b101, 40, 0);
        drive(3'b111, 30, 0);
        drive(3'b101, 40, 0);
        drive(3'b111, 10, 0);
        drive(3'b101, 8, 0);
        drive(3'b111, 30, 0);

        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 9) < 7) begin
                pick = legal[$urandom_range(0, 3)];
            end else begin
                pick = 3'($urandom_range(0, 7));
            end
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                              : int'($urandom_range(5, 30));
            drive(pick, len, int'($urandom_range(0, 3)));
        end

        // Reset while suspecting an impossible combination clears everything at once.
        drive(3'b011, 25, 0);
        drive(3'b101, 10, 0);
        @(negedge clock);
        #2 resetN = 1'b0;
        #1 check_eq("rst_code", bus.levelCode, 2'd0);
        check_eq("rst_lvl", {bus.highLevel, bus.mediumLevel, bus.lowLevel}, 3'b000);
        check_eq("rst_fault", bus.sensorFault, 1'b0);
        check_eq("rst_pulse", bus.levelChanged, 1'b0);
        {bus.probeHigh, bus.probeMedium, bus.probeLow} = 3'b000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        drive(3'b000, 20, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
